enc_parity_frame_ctrl: RTL and testbench

- Controller that shares one 4-bit Hamming parity encoder between two requesters, A and B.
- Each requester offers a word of NIBBLES nibbles. The controller arbitrates round-robin, takes the granted word, and sequences it through the encoder one nibble per beat.
- It emits a stream of 8-bit codewords under valid/ready handshake, tagged with source and last-beat flags.
- It sits between client word producers and the channel serializer in the encoder path.

---
 rtl/enc_parity_frame_ctrl_if.sv | 31 +++
 rtl/enc_parity_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_enc_parity_frame_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/enc_parity_frame_ctrl_if.sv
// Bundle of the requester, codeword and status signals around enc_parity_frame_ctrl.
// The slave modport is the controller's view; the master modport is the client/channel view.
interface enc_parity_frame_ctrl_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         a_valid;
   logic         a_ready;
   logic [W-1:0] a_data;
   logic         b_valid;
   logic         b_ready;
   logic [W-1:0] b_data;
   logic         cw_valid;
   logic         cw_ready;
   logic [7:0]   cw_data;
   logic         cw_src;
   logic         cw_last;
   logic         busy;
   logic [7:0]   frames_done;

   modport slave (
      input  a_valid, a_data, b_valid, b_data, cw_ready,
      output a_ready, b_ready, cw_valid, cw_data, cw_src, cw_last, busy, frames_done
   );

   modport master (
      output a_valid, a_data, b_valid, b_data, cw_ready,
      input  a_ready, b_ready, cw_valid, cw_data, cw_src, cw_last, busy, frames_done
   );
endinterface

// File: rtl/enc_parity_frame_ctrl.sv
// Round-robin arbiter feeding one 4-bit Hamming parity encoder from two word
// requesters; emits one 8-bit codeword {parity, nibble} per beat, LSB nibble first.
module enc_parity_frame_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   enc_parity_frame_ctrl_if.slave bus
);
   localparam int unsigned W        = 4 * NIBBLES;
   localparam logic [2:0]  LAST_IDX = 3'(NIBBLES - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Hamming parity: p0=d3^d2^d1, p1=d2^d1^d0, p2=d3^d1^d0, p3=d3^d2^d0.
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [3:0] p;
      p[0] = d[3] ^ d[2] ^ d[1];
      p[1] = d[2] ^ d[1] ^ d[0];
      p[2] = d[3] ^ d[1] ^ d[0];
      p[3] = d[3] ^ d[2] ^ d[0];
      return {p, d};
   endfunction

   state_e       state_q, state_d;
   logic         ptr_q, ptr_d;
   logic [W-1:0] shift_q, shift_d;
   logic [2:0]   cnt_q, cnt_d;
   logic         cw_valid_q, cw_valid_d;
   logic [7:0]   cw_data_q, cw_data_d;
   logic         cw_src_q, cw_src_d;
   logic         cw_last_q, cw_last_d;
   logic         busy_q, busy_d;
   logic [7:0]   frames_q, frames_d;

   logic         grant_b;
   logic         any_valid;
   logic [W-1:0] word;

   // Grant selection and the combinational ready strobes (held low during reset).
   always_comb begin
      any_valid   = bus.a_valid | bus.b_valid;
      grant_b     = bus.b_valid & (~bus.a_valid | ptr_q);
      word        = grant_b ? bus.b_data : bus.a_data;
      bus.a_ready = rst_n & (state_q == IDLE) & bus.a_valid & ~grant_b;
      bus.b_ready = rst_n & (state_q == IDLE) & grant_b;
   end

   // Next-state and next-output computation for the frame sequencer.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      cw_valid_d = cw_valid_q;
      cw_data_d  = cw_data_q;
      cw_src_d   = cw_src_q;
      cw_last_d  = cw_last_q;
      frames_d   = frames_q;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               shift_d    = word >> 4;
               cw_data_d  = enc(word[3:0]);
               cw_src_d   = grant_b;
               cw_last_d  = (NIBBLES == 1);
               cnt_d      = '0;
               cw_valid_d = 1'b1;
               ptr_d      = ~grant_b;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (cw_ready_hs()) begin
               if (cnt_q != LAST_IDX) begin
                  cw_data_d = enc(shift_q[3:0]);
                  shift_d   = shift_q >> 4;
                  cnt_d     = cnt_q + 3'd1;
                  cw_last_d = ((cnt_q + 3'd1) == LAST_IDX);
               end else begin
                  cw_valid_d = 1'b0;
                  cw_last_d  = 1'b0;
                  frames_d   = frames_q + 8'd1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SEND);
   end

   function automatic logic cw_ready_hs();
      return cw_valid_q & bus.cw_ready;
   endfunction

   // State and registered outputs; reset discards any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         shift_q    <= '0;
         cnt_q      <= '0;
         cw_valid_q <= 1'b0;
         cw_data_q  <= '0;
         cw_src_q   <= 1'b0;
         cw_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         cw_valid_q <= cw_valid_d;
         cw_data_q  <= cw_data_d;
         cw_src_q   <= cw_src_d;
         cw_last_q  <= cw_last_d;
         busy_q     <= busy_d;
         frames_q   <= frames_d;
      end
   end

   assign bus.cw_valid    = cw_valid_q;
   assign bus.cw_data     = cw_data_q;
   assign bus.cw_src      = cw_src_q;
   assign bus.cw_last     = cw_last_q;
   assign bus.busy        = busy_q;
   assign bus.frames_done = frames_q;

endmodule

// File: tb/tb_enc_parity_frame_ctrl.sv
// Directed bench for enc_parity_frame_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations for the documented scenarios.
module tb_enc_parity_frame_ctrl;
   localparam int unsigned NIB = 4;

   logic clk;
   logic rst_n;

   enc_parity_frame_ctrl_if #(.NIBBLES(NIB)) bus ();

   enc_parity_frame_ctrl #(.NIBBLES(NIB)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec  = 0;
   int nfail = 0;

   // Reference model state: pending codewords {src,last,data}, arbitration pointer, frame count.
   logic [9:0] exp_q[$];
   logic       m_ptr;
   logic [7:0] m_frames;
   // Codewords actually transferred, {src,last,data}.
   logic [9:0] cap[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_enc(input logic [3:0] d);
      return {^(d & 4'hD), ^(d & 4'hB), ^(d & 4'h7), ^(d & 4'hE), d};
   endfunction

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      logic       idle, ea, eb;
      logic [15:0] w;
      if (!rst_n) begin
         exp_q.delete();
         m_ptr    = 1'b0;
         m_frames = 8'd0;
         chk("rst_cw_valid", 32'(bus.cw_valid), 32'd0);
         chk("rst_cw_data", 32'(bus.cw_data), 32'd0);
         chk("rst_cw_src", 32'(bus.cw_src), 32'd0);
         chk("rst_cw_last", 32'(bus.cw_last), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_frames", 32'(bus.frames_done), 32'd0);
         chk("rst_ready", 32'({bus.a_ready, bus.b_ready}), 32'd0);
      end else begin
         idle = (exp_q.size() == 0);
         ea = idle && bus.a_valid && (!bus.b_valid || !m_ptr);
         eb = idle && bus.b_valid && (!bus.a_valid || m_ptr);
         chk("a_ready", 32'(bus.a_ready), 32'(ea));
         chk("b_ready", 32'(bus.b_ready), 32'(eb));
         chk("busy", 32'(bus.busy), 32'(!idle));
         chk("cw_valid", 32'(bus.cw_valid), 32'(!idle));
         chk("frames_done", 32'(bus.frames_done), 32'(m_frames));
         if (!idle) begin
            chk("cw_data", 32'(bus.cw_data), 32'(exp_q[0][7:0]));
            chk("cw_last", 32'(bus.cw_last), 32'(exp_q[0][8]));
            chk("cw_src", 32'(bus.cw_src), 32'(exp_q[0][9]));
            if (bus.cw_ready) begin
               cap.push_back({bus.cw_src, bus.cw_last, bus.cw_data});
               if (exp_q[0][8]) m_frames = m_frames + 8'd1;
               void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_cw_last", 32'(bus.cw_last), 32'd0);
            if (ea || eb) begin
               w = eb ? bus.b_data : bus.a_data;
               for (int i = 0; i < int'(NIB); i++)
                  exp_q.push_back({eb, (i == int'(NIB) - 1), m_enc(4'(w >> (4 * i)))});
               m_ptr = !eb;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 200) begin
         tick();
         n++;
      end
      if (bus.busy) begin
         nvec++;
         nfail++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_frame(input string name, input int base, input logic src,
                            input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
      logic [7:0] cw[4];
      cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3;
      for (int i = 0; i < 4; i++) begin
         if (cap.size() > base + i)
            chk(name, 32'(cap[base + i]), 32'({src, (i == 3), cw[i]}));
         else
            chk({name, "_missing"}, 32'(cap.size()), 32'(base + i + 1));
      end
   endtask

   initial begin
      int n;
      rst_n        = 1'b0;
      bus.a_valid  = 1'b0;
      bus.a_data   = '0;
      bus.b_valid  = 1'b0;
      bus.b_data   = '0;
      bus.cw_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Single word from A, no stall.
      cap.delete();
      bus.a_data = 16'h8421; bus.a_valid = 1'b1;
      tick();
      bus.a_valid = 1'b0;
      wait_idle();
      chk("t1_count", 32'(cap.size()), 32'd4);
      chk_frame("t1_cw", 0, 1'b0, 8'hE1, 8'h72, 8'hB4, 8'hD8);
      chk("t1_frames", 32'(bus.frames_done), 32'd1);

      // Encoder corners from B.
      cap.delete();
      bus.b_data = 16'hF0F0; bus.b_valid = 1'b1;
      tick();
      bus.b_valid = 1'b0;
      wait_idle();
      chk_frame("t2_cw", 0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF);

      // Contention after reset: A first, then strict alternation.
      do_reset();
      cap.delete();
      bus.a_data = 16'h1111; bus.b_data = 16'h2222;
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      n = 0;
      while (cap.size() < 16 && n < 100) begin
         tick();
         n++;
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      wait_idle();
      chk_frame("t3_a0", 0, 1'b0, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
      chk_frame("t3_b0", 4, 1'b1, 8'h72, 8'h72, 8'h72, 8'h72);
      chk_frame("t3_a1", 8, 1'b0, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
      chk_frame("t3_b1", 12, 1'b1, 8'h72, 8'h72, 8'h72, 8'h72);

      // Backpressure on beat 2 with B waiting.
      cap.delete();
      bus.a_data = 16'h8421; bus.a_valid = 1'b1;
      tick();
      bus.a_valid = 1'b0;
      tick();
      bus.cw_ready = 1'b0;
      bus.b_data = 16'h1234; bus.b_valid = 1'b1;
      repeat (5) begin
         tick();
         chk("t4_stall_data", 32'(bus.cw_data), 32'h72);
         chk("t4_stall_valid", 32'(bus.cw_valid), 32'd1);
         chk("t4_stall_b_ready", 32'(bus.b_ready), 32'd0);
      end
      bus.b_valid = 1'b0;
      bus.cw_ready = 1'b1;
      wait_idle();
      chk("t4_count", 32'(cap.size()), 32'd4);
      chk_frame("t4_cw", 0, 1'b0, 8'hE1, 8'h72, 8'hB4, 8'hD8);

      // Asynchronous reset in mid-frame, then A priority restored.
      bus.a_data = 16'h8421; bus.a_valid = 1'b1;
      tick();
      bus.a_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_cw_valid", 32'(bus.cw_valid), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_frames", 32'(bus.frames_done), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      cap.delete();
      bus.a_data = 16'h1111; bus.b_data = 16'h2222;
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      tick();
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      wait_idle();
      chk("t5_count", 32'(cap.size()), 32'd4);
      chk_frame("t5_cw", 0, 1'b0, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
      chk("t5_frames_after", 32'(bus.frames_done), 32'd1);

      // Frame counter wrap with back-to-back words from A.
      do_reset();
      bus.a_data = 16'h4321; bus.a_valid = 1'b1;
      n = 0;
      while (bus.frames_done != 8'd255 && n < 1400) begin
         tick();
         n++;
      end
      chk("t6_frames_255", 32'(bus.frames_done), 32'd255);
      n = 0;
      while (bus.frames_done != 8'd0 && n < 20) begin
         tick();
         n++;
      end
      chk("t6_frames_wrap", 32'(bus.frames_done), 32'd0);
      bus.a_valid = 1'b0;
      wait_idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
